// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit: FSM states, opcodes,
// branch funct3 values, ALU op encoding and trap causes.
package ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FETCH  = ST_FETCH,
    DECODE = ST_DECODE,
    EXEC   = ST_EXEC,
    WB     = ST_WB,
    TRAP   = ST_TRAP
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_TIMEOUT = 2'b10
  } trap_cause_t;

  function automatic logic is_branch_f3_legal(input logic [2:0] f3);
    return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

  // Only shifts (funct3=101) carry the arithmetic bit on I-type; elsewhere
  // instr[30] is immediate data and must not leak into the ALU op.
  function automatic logic [3:0] alu_ctrl(input logic [6:0] opcode,
                                          input logic [2:0] f3,
                                          input logic       f7b5);
    if (opcode == OP_B)      return ALU_SUB;
    else if (opcode == OP_R) return {f7b5, f3};
    else                     return {(f3 == 3'b101) & f7b5, f3};
  endfunction

endpackage

// File: rtl/ctrl_branch_unit.sv
// Branch resolution from datapath compare flags, plus the sign-extended
// B-type immediate used for the taken target.
module ctrl_branch_unit
  import ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        isZero,
  input  logic        isBLT,
  input  logic        isBGT,
  input  logic [6:0]  ir_hi,
  input  logic [4:0]  ir_lo,
  output logic        taken,
  output logic [31:0] imm_b
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = isZero;
      F3_BNE:  taken = !isZero;
      F3_BLT:  taken = isBLT;
      F3_BGE:  taken = isBGT | isZero;
      default: taken = 1'b0;
    endcase
  end

  // ir_hi = instr[31:25], ir_lo = instr[11:7]
  assign imm_b = {{20{ir_hi[6]}}, ir_lo[0], ir_hi[5:0], ir_lo[4:1], 1'b0};

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit for the non-pipelined RV32 datapath: owns PC and IR,
// fetches over a req/valid handshake and sequences R, I-ALU and branch instructions.
//
// state  | meaning
// IDLE   | parked at an instruction boundary, waiting for run
// FETCH  | imem_req high, waiting for imem_valid (bounded by FETCH_TIMEOUT)
// DECODE | IR holds the instruction; legality check
// EXEC   | ALU op driven; branches resolve and retire here
// WB     | register write strobe (unless rd=0), PC+4, retire
// TRAP   | terminal; only reset leaves
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        isZero,
  input  logic        isBLT,
  input  logic        isBGT,
  output logic [31:0] instr,
  output logic        regWrite,
  output logic        isALUreg,
  output logic [3:0]  alucontrol,
  output logic [31:0] pcNext,
  output logic        retired,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  trap_cause_t       cause_q, cause_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_r, is_i, is_b;
  logic        legal;
  logic        br_taken;
  logic [31:0] imm_b;
  logic        in_exwb;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign rd     = ir_q[11:7];
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_b   = (opcode == OP_B);
  assign legal  = is_r | is_i | (is_b & is_branch_f3_legal(funct3));

  ctrl_branch_unit u_branch (
    .funct3 (funct3),
    .isZero (isZero),
    .isBLT  (isBLT),
    .isBGT  (isBGT),
    .ir_hi  (ir_q[31:25]),
    .ir_lo  (ir_q[11:7]),
    .taken  (br_taken),
    .imm_b  (imm_b)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        // A valid arriving on the last allowed cycle still completes the fetch.
        if (imem_valid) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = DECODE;
        end else if (cnt_q == CNT_LAST) begin
          cause_d = TC_TIMEOUT;
          state_d = TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          cause_d = TC_ILLEGAL;
          state_d = TRAP;
        end
      end
      EXEC: begin
        if (is_b) begin
          pc_d    = br_taken ? (pc_q + imm_b) : (pc_q + 32'd4);
          state_d = run ? FETCH : IDLE;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        pc_d    = pc_q + 32'd4;
        state_d = run ? FETCH : IDLE;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Moore outputs: everything below depends only on registered state.
  assign in_exwb    = (state_q == EXEC) || (state_q == WB);
  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign pcNext     = pc_q;
  assign instr      = ir_q;
  assign alucontrol = in_exwb ? alu_ctrl(opcode, funct3, ir_q[30]) : 4'b0000;
  assign isALUreg   = in_exwb & (is_r | is_b);
  assign regWrite   = (state_q == WB) && (rd != 5'd0);
  assign retired    = (state_q == WB) || ((state_q == EXEC) && is_b);
  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: ALU/branch sequencing, wait states,
// traps, PC wrap, reset mid-instruction and run deassertion.
module tb_multicycle_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        isZero, isBLT, isBGT;
  logic [31:0] instr;
  logic        regWrite;
  logic        isALUreg;
  logic [3:0]  alucontrol;
  logic [31:0] pcNext;
  logic        retired;
  logic        trap;
  logic [1:0]  trap_cause;

  int n_checks = 0;
  int n_err    = 0;

  multicycle_ctrl_fsm #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .isZero     (isZero),
    .isBLT      (isBLT),
    .isBGT      (isBGT),
    .instr      (instr),
    .regWrite   (regWrite),
    .isALUreg   (isALUreg),
    .alucontrol (alucontrol),
    .pcNext     (pcNext),
    .retired    (retired),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered while the FSM sits in its first FETCH cycle; leaves it in the next FETCH.
  task automatic run_alu(input string tag, input logic [31:0] ins, input int waits,
                         input logic [3:0] exp_alu, input logic exp_rw,
                         input logic exp_isreg, input logic [31:0] exp_pc);
    logic [31:0] pc0;
    pc0 = imem_addr;
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    for (int w = 0; w < waits; w++) begin
      step();
      chk({tag, "_req_wait"}, {31'd0, imem_req}, 32'd1);
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    step();
    imem_valid = 1'b0;
    chk({tag, "_ir"}, instr, ins);
    step();
    chk({tag, "_ex_alu"}, {28'd0, alucontrol}, {28'd0, exp_alu});
    chk({tag, "_ex_isreg"}, {31'd0, isALUreg}, {31'd0, exp_isreg});
    chk({tag, "_ex_rw_ret"}, {30'd0, regWrite, retired}, 32'd0);
    step();
    chk({tag, "_wb_rw"}, {31'd0, regWrite}, {31'd0, exp_rw});
    chk({tag, "_wb_ret"}, {31'd0, retired}, 32'd1);
    chk({tag, "_wb_alu"}, {27'd0, isALUreg, alucontrol}, {27'd0, exp_isreg, exp_alu});
    chk({tag, "_wb_pc"}, pcNext, pc0);
    step();
    chk({tag, "_pc"}, pcNext, exp_pc);
    chk({tag, "_rw_off"}, {30'd0, regWrite, retired}, 32'd0);
  endtask

  task automatic run_br(input string tag, input logic [31:0] ins,
                        input logic z, input logic lt, input logic gt,
                        input logic [31:0] exp_pc);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    imem_valid = 1'b1;
    imem_rdata = ins;
    step();
    imem_valid = 1'b0;
    isZero = z; isBLT = lt; isBGT = gt;
    step();
    chk({tag, "_ex_alu"}, {27'd0, isALUreg, alucontrol}, {27'd0, 1'b1, 4'b1000});
    chk({tag, "_ex_ret"}, {30'd0, retired, regWrite}, 32'd2);
    step();
    isZero = 1'b0; isBLT = 1'b0; isBGT = 1'b0;
    chk({tag, "_pc"}, pcNext, exp_pc);
    chk({tag, "_addr"}, imem_addr, exp_pc);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_async_trap", {29'd0, trap, trap_cause}, 32'd0);
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    isZero = 1'b0; isBLT = 1'b0; isBGT = 1'b0;
    step(); step();
    chk("rst_pc", pcNext, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_strobes", {25'd0, imem_req, regWrite, retired, trap, isALUreg, trap_cause}, 32'd0);
    chk("rst_alu", {28'd0, alucontrol}, 32'd0);
    reset = 1'b1;
    step();
    chk("idle_no_run", {31'd0, imem_req}, 32'd0);
    run = 1'b1;
    step();

    run_alu("add",     32'h002081B3, 0, 4'b0000, 1'b1, 1'b1, 32'h4);
    run_alu("sub",     32'h402081B3, 3, 4'b1000, 1'b1, 1'b1, 32'h8);
    run_alu("addi_x0", 32'hC0000013, 0, 4'b0000, 1'b0, 1'b0, 32'hC);
    run_alu("srai",    32'h4032D293, 0, 4'b1101, 1'b1, 1'b0, 32'h10);

    run_br("beq_t",  32'hFE000CE3, 1'b1, 1'b0, 1'b0, 32'h08);
    run_br("bge_eq", 32'h00005463, 1'b1, 1'b0, 1'b0, 32'h10);
    run_br("beq_nt", 32'hFE000CE3, 1'b0, 1'b1, 1'b0, 32'h14);
    run_br("blt_t",  32'h00004463, 1'b0, 1'b1, 1'b0, 32'h1C);
    run_br("bne_nt", 32'h00001463, 1'b1, 1'b0, 1'b1, 32'h20);

    // reset asserted in the middle of a WB cycle
    imem_valid = 1'b1; imem_rdata = 32'h002081B3;
    step();
    imem_valid = 1'b0;
    step(); step();
    chk("wbrst_pre_rw", {31'd0, regWrite}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("wbrst_rw", {30'd0, regWrite, retired}, 32'd0);
    chk("wbrst_pc", pcNext, 32'h0);
    chk("wbrst_ir", instr, 32'h0);
    step();
    reset = 1'b1;
    step();

    // illegal opcode: terminal trap
    imem_valid = 1'b1; imem_rdata = 32'h0000_0003;
    step();
    imem_valid = 1'b0;
    step();
    chk("ill_trap", {30'd0, trap_cause}, 32'd1);
    chk("ill_flag", {31'd0, trap}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      imem_valid = i[0]; imem_rdata = 32'h002081B3;
      step();
      chk("ill_hold", {28'd0, trap, imem_req, retired, regWrite}, 32'h8);
    end
    imem_valid = 1'b0;
    do_reset();

    // B-type with reserved funct3
    imem_valid = 1'b1; imem_rdata = 32'h0000_2463;
    step();
    imem_valid = 1'b0;
    step();
    chk("bf3_trap", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'b01});
    do_reset();

    // fetch timeout
    chk("to_c1", {30'd0, imem_req, trap}, 32'd2);
    for (int i = 2; i <= 16; i++) begin
      step();
      chk("to_wait", {30'd0, imem_req, trap}, 32'd2);
    end
    step();
    chk("to_trap", {29'd0, trap, trap_cause}, {29'd0, 1'b1, 2'b10});
    chk("to_req", {31'd0, imem_req}, 32'd0);
    do_reset();

    // valid on the final allowed cycle wins
    for (int i = 2; i <= 16; i++) step();
    imem_valid = 1'b1; imem_rdata = 32'h002081B3;
    step();
    imem_valid = 1'b0;
    chk("to_last_notrap", {29'd0, trap, trap_cause}, 32'd0);
    chk("to_last_ir", instr, 32'h002081B3);
    do_reset();

    // PC wrap through 0xFFFF_FFFC and run dropped during EXEC
    run_br("beq_wrap", 32'hFE000EE3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    imem_valid = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_valid = 1'b0;
    step();
    run = 1'b0;
    chk("stop_ex_ret", {31'd0, retired}, 32'd0);
    step();
    chk("stop_wb", {30'd0, retired, regWrite}, 32'd2);
    step();
    chk("wrap_pc", pcNext, 32'h0);
    chk("stop_idle", {31'd0, imem_req}, 32'd0);
    step(); step();
    chk("stop_parked", {30'd0, imem_req, retired}, 32'd0);
    run = 1'b1;
    step();
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
